// File: rtl/snake_body_tracker_if.sv
// Bundles the snake tracker's control, read-port and status signals.
// Port summary (direction as seen by the tracker / slave):
//   init_i, step_i, dir_i[1:0], grow_i, rd_idx_i[IW-1:0]   : inputs
//   rd_x_c[7:0], rd_y_c[6:0], rd_valid_c                    : combinational read port
//   length_o[IW:0], tail_x_o[7:0], tail_y_o[6:0], tail_vld_o,
//   busy_o, done_o, hit_wall_o, hit_self_o                  : registered status
interface snake_body_tracker_if #(
    parameter int unsigned MAX_LEN = 16
);
    localparam int unsigned IW = $clog2(MAX_LEN);

    logic          init_i;
    logic          step_i;
    logic [1:0]    dir_i;
    logic          grow_i;
    logic [IW-1:0] rd_idx_i;
    logic [7:0]    rd_x_c;
    logic [6:0]    rd_y_c;
    logic          rd_valid_c;
    logic [IW:0]   length_o;
    logic [7:0]    tail_x_o;
    logic [6:0]    tail_y_o;
    logic          tail_vld_o;
    logic          busy_o;
    logic          done_o;
    logic          hit_wall_o;
    logic          hit_self_o;

    modport slave (
        input  init_i, step_i, dir_i, grow_i, rd_idx_i,
        output rd_x_c, rd_y_c, rd_valid_c, length_o, tail_x_o, tail_y_o,
               tail_vld_o, busy_o, done_o, hit_wall_o, hit_self_o
    );

    modport master (
        output init_i, step_i, dir_i, grow_i, rd_idx_i,
        input  rd_x_c, rd_y_c, rd_valid_c, length_o, tail_x_o, tail_y_o,
               tail_vld_o, busy_o, done_o, hit_wall_o, hit_self_o
    );
endinterface

// File: rtl/snake_body_tracker.sv
// Holds the pixel coordinates of every snake segment (head at index 0),
// advances the body one cell per step, grows on request and flags wall and
// self collisions. Feeds the VGA draw/erase FSM.
// Ports:
//   clk    : system clock
//   rst_n  : asynchronous active-low reset
//   bus    : snake_body_tracker_if.slave (control in, read port and status out)
module snake_body_tracker #(
    parameter int unsigned MAX_LEN  = 16,
    parameter int unsigned INIT_LEN = 4,
    parameter int unsigned XDIM     = 10,
    parameter int unsigned YDIM     = 10,
    parameter int unsigned XSCREEN  = 160,
    parameter int unsigned YSCREEN  = 120,
    parameter int unsigned X_INIT   = 80,
    parameter int unsigned Y_INIT   = 60
) (
    input logic                  clk,
    input logic                  rst_n,
    snake_body_tracker_if.slave  bus
);
    localparam int unsigned IW = $clog2(MAX_LEN);
    localparam int unsigned LW = IW + 1;

    localparam logic [1:0] DIR_RIGHT = 2'b00;
    localparam logic [1:0] DIR_DOWN  = 2'b01;
    localparam logic [1:0] DIR_UP    = 2'b10;

    typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_CHECK, S_DONE} state_e;

    state_e        state_q, state_d;
    logic [1:0]    cur_dir_q, cur_dir_d;
    logic          grow_q, grow_d;
    logic [IW-1:0] k_q, k_d;
    logic [LW-1:0] length_q, length_d;
    logic [7:0]    seg_x_q [MAX_LEN];
    logic [7:0]    seg_x_d [MAX_LEN];
    logic [6:0]    seg_y_q [MAX_LEN];
    logic [6:0]    seg_y_d [MAX_LEN];
    logic [7:0]    tail_x_q, tail_x_d;
    logic [6:0]    tail_y_q, tail_y_d;
    logic          tail_vld_q, tail_vld_d;
    logic          hit_wall_q, hit_wall_d;
    logic          hit_self_q, hit_self_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;

    logic [7:0]    nh_x;
    logic [6:0]    nh_y;
    logic          wall_c;
    logic [IW-1:0] last_idx;

    function automatic logic [7:0] init_x(int unsigned i);
        if (i < INIT_LEN) return 8'(X_INIT - i * XDIM);
        return 8'd0;
    endfunction

    function automatic logic [6:0] init_y(int unsigned i);
        if (i < INIT_LEN) return 7'(Y_INIT);
        return 7'd0;
    endfunction

    // Candidate new head and wall test; widened sums so nothing wraps.
    always_comb begin
        nh_x   = seg_x_q[0];
        nh_y   = seg_y_q[0];
        wall_c = 1'b0;
        case (cur_dir_q)
            DIR_RIGHT: begin
                wall_c = (9'(seg_x_q[0]) + 9'(XDIM)) > 9'(XSCREEN - XDIM);
                nh_x   = seg_x_q[0] + 8'(XDIM);
            end
            DIR_DOWN: begin
                wall_c = (8'(seg_y_q[0]) + 8'(YDIM)) > 8'(YSCREEN - YDIM);
                nh_y   = seg_y_q[0] + 7'(YDIM);
            end
            DIR_UP: begin
                wall_c = seg_y_q[0] < 7'(YDIM);
                nh_y   = seg_y_q[0] - 7'(YDIM);
            end
            default: begin
                wall_c = seg_x_q[0] < 8'(XDIM);
                nh_x   = seg_x_q[0] - 8'(XDIM);
            end
        endcase
    end

    assign last_idx = IW'(length_q - LW'(1));

    // Next-state and datapath updates; init overrides everything last.
    always_comb begin
        state_d    = state_q;
        cur_dir_d  = cur_dir_q;
        grow_d     = grow_q;
        k_d        = k_q;
        length_d   = length_q;
        seg_x_d    = seg_x_q;
        seg_y_d    = seg_y_q;
        tail_x_d   = tail_x_q;
        tail_y_d   = tail_y_q;
        tail_vld_d = tail_vld_q;
        hit_wall_d = hit_wall_q;
        hit_self_d = hit_self_q;

        case (state_q)
            S_IDLE: begin
                if (bus.step_i && !hit_wall_q && !hit_self_q) begin
                    state_d = S_SHIFT;
                    grow_d  = bus.grow_i;
                    // Opposite directions differ in both bits.
                    if ((bus.dir_i ^ cur_dir_q) != 2'b11) cur_dir_d = bus.dir_i;
                end
            end
            S_SHIFT: begin
                if (wall_c) begin
                    hit_wall_d = 1'b1;
                    tail_vld_d = 1'b0;
                    state_d    = S_DONE;
                end else begin
                    tail_x_d = seg_x_q[last_idx];
                    tail_y_d = seg_y_q[last_idx];
                    for (int unsigned i = 1; i < MAX_LEN; i++) begin
                        seg_x_d[i] = seg_x_q[i-1];
                        seg_y_d[i] = seg_y_q[i-1];
                    end
                    seg_x_d[0] = nh_x;
                    seg_y_d[0] = nh_y;
                    // The old tail stays in place as the new last segment when growing.
                    if (grow_q && (length_q < LW'(MAX_LEN))) begin
                        length_d   = length_q + LW'(1);
                        tail_vld_d = 1'b0;
                    end else begin
                        tail_vld_d = 1'b1;
                    end
                    k_d     = IW'(1);
                    state_d = (length_d == LW'(1)) ? S_DONE : S_CHECK;
                end
            end
            S_CHECK: begin
                if ((seg_x_q[k_q] == seg_x_q[0]) && (seg_y_q[k_q] == seg_y_q[0]))
                    hit_self_d = 1'b1;
                if ({1'b0, k_q} == last_idx_ext(length_q)) state_d = S_DONE;
                else                                        k_d     = k_q + IW'(1);
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        if (bus.init_i) begin
            state_d    = S_IDLE;
            cur_dir_d  = DIR_RIGHT;
            grow_d     = 1'b0;
            k_d        = '0;
            length_d   = LW'(INIT_LEN);
            tail_x_d   = '0;
            tail_y_d   = '0;
            tail_vld_d = 1'b0;
            hit_wall_d = 1'b0;
            hit_self_d = 1'b0;
            for (int unsigned i = 0; i < MAX_LEN; i++) begin
                seg_x_d[i] = init_x(i);
                seg_y_d[i] = init_y(i);
            end
        end

        busy_d = (state_d != S_IDLE);
        done_d = (state_d == S_DONE);
    end

    function automatic logic [LW-1:0] last_idx_ext(logic [LW-1:0] len);
        return len - LW'(1);
    endfunction

    // State and datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            cur_dir_q  <= DIR_RIGHT;
            grow_q     <= 1'b0;
            k_q        <= '0;
            length_q   <= LW'(INIT_LEN);
            tail_x_q   <= '0;
            tail_y_q   <= '0;
            tail_vld_q <= 1'b0;
            hit_wall_q <= 1'b0;
            hit_self_q <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            for (int unsigned i = 0; i < MAX_LEN; i++) begin
                seg_x_q[i] <= init_x(i);
                seg_y_q[i] <= init_y(i);
            end
        end else begin
            state_q    <= state_d;
            cur_dir_q  <= cur_dir_d;
            grow_q     <= grow_d;
            k_q        <= k_d;
            length_q   <= length_d;
            tail_x_q   <= tail_x_d;
            tail_y_q   <= tail_y_d;
            tail_vld_q <= tail_vld_d;
            hit_wall_q <= hit_wall_d;
            hit_self_q <= hit_self_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            for (int unsigned i = 0; i < MAX_LEN; i++) begin
                seg_x_q[i] <= seg_x_d[i];
                seg_y_q[i] <= seg_y_d[i];
            end
        end
    end

    // Read port: zero outside the live body.
    assign bus.rd_valid_c = ({1'b0, bus.rd_idx_i} < length_q);
    assign bus.rd_x_c     = bus.rd_valid_c ? seg_x_q[bus.rd_idx_i] : 8'd0;
    assign bus.rd_y_c     = bus.rd_valid_c ? seg_y_q[bus.rd_idx_i] : 7'd0;

    assign bus.length_o   = length_q;
    assign bus.tail_x_o   = tail_x_q;
    assign bus.tail_y_o   = tail_y_q;
    assign bus.tail_vld_o = tail_vld_q;
    assign bus.busy_o     = busy_q;
    assign bus.done_o     = done_q;
    assign bus.hit_wall_o = hit_wall_q;
    assign bus.hit_self_o = hit_self_q;

endmodule
